im_loader: RTL and testbench
============================

Name: im_loader

Overview:
Writer-side counterpart to the instruction memory that the single-cycle CPU reads. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions. Each assembled word is written into IM at consecutive word addresses starting from 0. The CPU is held in reset until the load completes, so the core boots from freshly loaded code instead of a simulator $readmemh.

Parameters:
bit_size, 32, instruction/data word width (fixed at 4 bytes)
mem_size, 16, IM word-address width and word_count width
HOLD_CYCLES, 2, cycles cpu_rst stays high after the last IM write (legal range >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  load request; sampled only in IDLE or DONE
word_count  input  mem_size  number of words to load; latched when start is accepted
byte_in  input  8  stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader can accept a byte this cycle
IM_Write_Address  output  mem_size  IM word address
IM_Write_Data  output  bit_size  assembled instruction word
IM_Write_enable  output  1  one-cycle IM write strobe
cpu_rst  output  1  reset to the CPU top
busy  output  1  load in progress (COLLECT, WRITE or HOLD)
done  output  1  load complete; sticky until next start or rst
checksum  output  bit_size  XOR of all words written in the current load

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; byte_ready=0; IM_Write_enable=0; IM_Write_Address=0; IM_Write_Data=0.
  - cpu_rst=1; busy=0; done=0; checksum=0; byte count=0.
  - rst mid-load discards any partial word and issues no write; the next load restarts at address 0.
- States:
  - IDLE: cpu_rst=1. A start edge latches word_count, clears the address counter, byte count and checksum, sets busy=1. Next state is COLLECT, or HOLD if word_count==0.
  - COLLECT: byte_ready=1. A byte transfers on any cycle with byte_valid & byte_ready.
    - Bytes fill the word big-endian: first byte goes to [31:24], fourth byte to [7:0].
    - After the 4th accepted byte, next state is WRITE. byte_valid gaps stall collection with no timeout.
  - WRITE: exactly one cycle.
    - byte_ready=0; IM_Write_enable=1; IM_Write_Address=current index; IM_Write_Data=assembled word.
    - checksum updates to checksum^word on the following edge.
    - If index==word_count-1, next state is HOLD; otherwise index increments and the state returns to COLLECT.
  - HOLD: byte_ready=0; cpu_rst=1; busy=1. Lasts exactly HOLD_CYCLES cycles, then goes to DONE.
  - DONE: cpu_rst=0; busy=0; done=1; byte_ready=0. A start edge behaves as in IDLE, clears done and reasserts cpu_rst in the next cycle.
- Timing:
  - Start accepted at edge E: byte_ready=1 from cycle E+1.
  - Minimum cost per word is 5 cycles (4 byte cycles + 1 write cycle).
  - Last write in cycle W: HOLD occupies W+1..W+HOLD_CYCLES; cpu_rst=0 and done=1 from cycle W+HOLD_CYCLES+1.
- Boundary conditions:
  - start in COLLECT, WRITE or HOLD is ignored. word_count is not re-sampled mid-load.
  - byte_valid outside COLLECT is not accepted (byte_ready=0); the byte is not consumed.
  - Outputs other than IM_Write_enable hold their last values between writes.
  - IM_Write_enable is 0 in every state except WRITE.
  - No address wrap: index never exceeds word_count-1 (maximum 2^mem_size-1 words).
  - rst has priority over start and over byte handshakes in the same cycle.

Test Plan:
1. Reset, start with word_count=2, bytes 8C,01,00,00,20,02,00,05 back-to-back -> writes addr0=8C010000 and addr1=20020005, each as a single-cycle strobe; checksum=AC030005; cpu_rst falls 2 cycles after the second write; done=1, busy=0.
2. Same load with byte_valid low for 3 cycles between every byte -> identical writes and checksum; no IM_Write_enable until 4 bytes are accepted; byte_ready stays 1 throughout COLLECT.
3. word_count=0 -> no IM_Write_enable pulse; HOLD lasts 2 cycles; done=1, cpu_rst=0, checksum=0.
4. rst asserted after 2 bytes of word 0 -> no write issued; all outputs at reset values, cpu_rst=1. A fresh load with word_count=1 and bytes 00,00,00,0C writes addr0=0000000C.
5. start pulsed during COLLECT -> ignored, addresses continue sequentially. start after DONE -> done clears, cpu_rst=1 next cycle, new load begins at addr 0 and checksum restarts from 0.
6. byte_valid=1 with data AA in IDLE and DONE -> byte_ready=0, no byte consumed. The first byte accepted after start lands in [31:24].

Source files
------------

// File: rtl/im_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian 32-bit words,
// writes them to consecutive IM addresses and holds the CPU in reset until done.
module im_loader #(
  parameter int bit_size    = 32,
  parameter int mem_size    = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [mem_size-1:0] word_count,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  output logic [mem_size-1:0] IM_Write_Address,
  output logic [bit_size-1:0] IM_Write_Data,
  output logic                IM_Write_enable,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic [bit_size-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [mem_size-1:0] count_q, count_d;
  logic [mem_size-1:0] index_q, index_d;
  logic [mem_size-1:0] addr_q, addr_d;
  logic [bit_size-9:0] shift_q, shift_d;
  logic [bit_size-1:0] data_q, data_d;
  logic [bit_size-1:0] cks_q, cks_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [31:0]         hold_q, hold_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    data_d  = data_q;
    cks_d   = cks_q;
    bcnt_d  = bcnt_q;
    hold_d  = hold_q;

    byte_ready      = (state_q == S_COLLECT);
    IM_Write_enable = (state_q == S_WRITE);
    cpu_rst         = (state_q != S_DONE);
    busy            = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_HOLD);
    done            = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          count_d = word_count;
          index_d = '0;
          bcnt_d  = '0;
          cks_d   = '0;
          hold_d  = '0;
          state_d = (word_count == '0) ? S_HOLD : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (byte_valid) begin
          // Only the first three bytes are kept; the fourth goes straight into the word.
          shift_d = {shift_q[bit_size-17:0], byte_in};
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            data_d  = {shift_q, byte_in};
            addr_d  = index_q;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        cks_d = cks_q ^ data_q;
        if (index_q == count_q - mem_size'(1)) begin
          hold_d  = '0;
          state_d = S_HOLD;
        end else begin
          index_d = index_q + mem_size'(1);
          state_d = S_COLLECT;
        end
      end
      S_HOLD: begin
        if (hold_q == 32'(HOLD_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cks_q   <= '0;
      bcnt_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cks_q   <= cks_d;
      bcnt_q  <= bcnt_d;
      hold_q  <= hold_d;
    end
  end

  assign IM_Write_Address = addr_q;
  assign IM_Write_Data    = data_q;
  assign checksum         = cks_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: table of full loads plus hand-written corner sequences.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] IM_Write_Address;
  logic [31:0] IM_Write_Data;
  logic        IM_Write_enable;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  im_loader #(.bit_size(32), .mem_size(16), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .IM_Write_Address(IM_Write_Address), .IM_Write_Data(IM_Write_Data),
    .IM_Write_enable(IM_Write_enable), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cyc = 0;
  int last_wr_cyc = -1;
  int br_drop = 0;
  logic [15:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (IM_Write_enable) begin
      wr_addr.push_back(IM_Write_Address);
      wr_data.push_back(IM_Write_Data);
      last_wr_cyc = cyc;
    end
    if (busy) busy_cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] wc);
    busy_cyc = 0;
    last_wr_cyc = -1;
    br_drop = 0;
    wr_addr.delete();
    wr_data.delete();
    word_count = wc;
    start = 1'b1;
    tick();
    start = 1'b0;
    word_count = '1;
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    if (wc != 0) chk("start_byte_ready", 32'(byte_ready), 32'd1);
  endtask

  // Sends n bytes from a left-aligned 96-bit field; optionally pulses start before byte start_at.
  task automatic send_bytes(input logic [95:0] data, input int n, input int gap, input int start_at);
    logic [95:0] d;
    int to;
    d = data;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap; g++) begin
        byte_valid = 1'b0;
        if (!(g == 0 && k % 4 == 0 && k > 0) && !byte_ready) br_drop++;
        tick();
      end
      if (k == start_at) begin
        word_count = 16'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      byte_valid = 1'b1;
      byte_in = d[95:88];
      d = d << 8;
      to = 0;
      while (!byte_ready && to < 20) begin
        tick();
        to++;
      end
      if (to >= 20) begin
        checks++;
        errors++;
        $display("FAIL byte_accept_timeout actual=%0d required=<20", to);
      end
      if (k == 3) chk("no_early_we", 32'(wr_data.size()), 32'd0);
      tick();
      byte_valid = 1'b0;
    end
  endtask

  task automatic finish_load(input int nwr, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] cks, input int busy_exp);
    logic [31:0] exp_d[3];
    int to;
    exp_d[0] = d0;
    exp_d[1] = d1;
    exp_d[2] = d2;
    to = 0;
    @(negedge clk);
    while (!done && to < 100) begin
      @(negedge clk);
      to++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("n_writes", 32'(wr_data.size()), 32'(nwr));
    for (int i = 0; i < nwr && i < wr_data.size(); i++) begin
      chk("wr_addr", 32'(wr_addr[i]), 32'(i));
      chk("wr_data", wr_data[i], exp_d[i]);
    end
    chk("checksum", checksum, cks);
    chk("busy_end", 32'(busy), 32'd0);
    chk("cpu_rst_end", 32'(cpu_rst), 32'd0);
    chk("byte_ready_done", 32'(byte_ready), 32'd0);
    if (busy_exp >= 0) chk("busy_cycles", 32'(busy_cyc), 32'(busy_exp));
    if (nwr > 0) chk("hold_latency", 32'(cyc - last_wr_cyc), 32'd3);
    chk("br_stays_high", 32'(br_drop), 32'd0);
    tick();
  endtask

  typedef struct {
    logic [15:0] wc;
    logic [95:0] bytes;
    int          gap;
    int          nwr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] cks;
    int          busy;
  } vec_t;

  vec_t vt[4];

  initial begin
    vt[0] = '{16'd2, 96'h8C01000020020005_00000000, 0, 2, 32'h8C010000, 32'h20020005, 32'hAC030005, 12};
    vt[1] = '{16'd2, 96'h8C01000020020005_00000000, 3, 2, 32'h8C010000, 32'h20020005, 32'hAC030005, 35};
    vt[2] = '{16'd2, 96'hDEADBEEF12345678_00000000, 1, 2, 32'hDEADBEEF, 32'h12345678, 32'hCC99E897, 19};
    vt[3] = '{16'd0, 96'h0, 0, 0, 32'h0, 32'h0, 32'h0, 2};

    rst = 1'b1;
    start = 1'b0;
    word_count = '0;
    byte_in = '0;
    byte_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("rst_we", 32'(IM_Write_enable), 32'd0);
    chk("rst_addr", 32'(IM_Write_Address), 32'd0);
    chk("rst_data", IM_Write_Data, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_checksum", checksum, 32'd0);

    // Byte offered in IDLE is refused
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    br_drop = 0;
    for (int i = 0; i < 3; i++) begin
      if (byte_ready) br_drop++;
      tick();
    end
    byte_valid = 1'b0;
    chk("idle_refuse", 32'(br_drop), 32'd0);

    for (int v = 0; v < 4; v++) begin
      do_start(vt[v].wc);
      send_bytes(vt[v].bytes, 4 * int'(vt[v].wc), vt[v].gap, -1);
      finish_load(vt[v].nwr, vt[v].d0, vt[v].d1, 32'h0, vt[v].cks, vt[v].busy);
    end

    // Byte offered in DONE is refused and not consumed
    byte_valid = 1'b1;
    byte_in = 8'hAA;
    br_drop = 0;
    for (int i = 0; i < 3; i++) begin
      if (byte_ready) br_drop++;
      tick();
    end
    byte_valid = 1'b0;
    chk("done_refuse", 32'(br_drop), 32'd0);
    do_start(16'd1);
    send_bytes(96'h11223344_0000000000000000, 4, 0, -1);
    finish_load(1, 32'h11223344, 32'h0, 32'h0, 32'h11223344, 7);

    // start pulsed mid-collect is ignored
    do_start(16'd3);
    send_bytes(96'h01020304_05060708_090A0B0C, 12, 0, 2);
    exp_three: finish_load(3, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F00, -1);

    // rst mid-load discards the partial word
    do_start(16'd2);
    send_bytes(96'hCAFE0000_0000000000000000, 2, 0, -1);
    rst = 1'b1;
    byte_valid = 1'b1;
    byte_in = 8'h77;
    start = 1'b1;
    tick();
    rst = 1'b0;
    byte_valid = 1'b0;
    start = 1'b0;
    chk("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_addr", 32'(IM_Write_Address), 32'd0);
    chk("mid_rst_data", IM_Write_Data, 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_checksum", checksum, 32'd0);
    tick();
    tick();
    chk("mid_rst_no_write", 32'(wr_data.size()), 32'd0);
    do_start(16'd1);
    send_bytes(96'h0000000C_0000000000000000, 4, 0, -1);
    finish_load(1, 32'h0000000C, 32'h0, 32'h0, 32'h0000000C, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finished", cyc);
    $fatal(1);
  end

endmodule
